bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and sequencer for the memory-mapped system bus. Master 0 is the CPU data port and master 1 is a secondary requester (instruction fetch or debug/DMA). The block grants the bus round-robin and drives one word access at a time into the address decoder. It waits for the selected slave's ready and returns read data with a one-cycle acknowledge. A watchdog aborts any access whose slave never responds and reports a bus error.

## Interface
- TIMEOUT, 255: cycles an access may wait for `bus_ready` before abort; 0 disables the watchdog. Counter width is clog2(TIMEOUT+1), minimum 1.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  access request; held until the matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_rdata, m1_rdata  out  32  read data; valid while the matching ack is high
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- bus_addr  out  32  word-aligned address to the decoder
- bus_re, bus_we  out  1  read / write strobe; mutually exclusive
- bus_wdata  out  32  write data to the slave
- bus_rdata  in  32  slave read data
- bus_ready  in  1  slave completion, sampled only while a strobe is high
- err  out  1  one-cycle pulse on watchdog abort
- err_addr  out  32  address of the most recent aborted access; sticky
- owner  out  1  index of the current or last granted master

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master that is not `owner`, so service alternates.
  - On grant: latch we, addr, wdata and the master index into `owner`, clear the watchdog counter, go to ACCESS.
- **ACCESS**
  - Drives `bus_addr` = {latched addr[31:2], 2'b00} and `bus_wdata`.
  - Drives `bus_we` = latched we and `bus_re` = ~latched we.
  - Counter increments each cycle.
  - `bus_ready` high at an edge: latch `bus_rdata` (zero for writes), go to RESP.
  - Otherwise, if TIMEOUT≠0 and the counter reaches TIMEOUT-1 at that edge: latch rdata = 0, pulse `err` in the following cycle, load `err_addr`, go to RESP.
  - `bus_ready` and timeout at the same edge: ready wins and there is no error.
- **RESP**
  - Strobes low; owner's ack high; owner's rdata = latched data; the other master's ack low.
  - Always returns to IDLE. RESP exists so a request still held during the ack cycle is not re-issued.
- Non-owner rdata reads 0.
- Requests seen in ACCESS or RESP are ignored until IDLE.
- Owner dropping req mid-access does not cancel it: the access completes and ack still pulses.
- Latched fields do not change during ACCESS, even if the master's inputs change.

## Timing
- Reset (async assert, sync release)
  - State goes to IDLE.
  - All outputs go to 0: acks, strobes, bus_addr, bus_wdata, rdata, err, err_addr.
  - `owner` resets to 1, so master 0 wins the first tie.
  - Reset mid-ACCESS drops strobes immediately and no ack is issued.
- Request sampled high at edge k.
  - Strobes are high from k through the edge where ready is sampled, edge k+n (n ≥ 1).
  - Ack is high during the cycle after edge k+n.
- Zero-wait slave (`bus_ready` always high): ack in cycle k+1 to k+2. Back-to-back throughput is one access per 3 cycles.
- Watchdog abort: strobes are high for exactly TIMEOUT cycles. `err` and ack are high in the same cycle.
- Strobes, ack and err are registered (glitch-free). `bus_addr` and `bus_wdata` are registered and stable for the whole ACCESS.

## Test plan
- Single read, m0: addr 0x10000007, slave returns 0xDEADBEEF after 2 wait cycles.
  - Expect `bus_addr` = 0x10000004 and `bus_re` high for 3 cycles, then `m0_ack` for 1 cycle with `m0_rdata` = 0xDEADBEEF.
  - Expect `m1_ack` = 0 throughout.
- Contention, zero-wait slave: both masters hold req for 4 writes each.
  - Expect grant order m0, m1, m0, m1, …
  - Expect each ack 3 cycles apart, with `bus_wdata` matching the granted master's data.
- Watchdog, TIMEOUT=4: m1 reads 0xF0900000 with `bus_ready` held low.
  - Expect `bus_re` high for exactly 4 cycles, then `m1_ack` with `m1_rdata` = 0.
  - Expect `err` high that same cycle and `err_addr` = 0xF0900000.
  - Expect the next access to proceed normally.
- Ready on the timeout edge: TIMEOUT=4, `bus_ready` rises at the 4th edge. Expect normal ack and `err` = 0.
- Reset mid-ACCESS: assert `rst` low while `bus_we` is high.
  - Expect `bus_we` low asynchronously and no ack.
  - After release: all outputs 0, `owner` = 1, and a simultaneous m0/m1 request grants m0 first.
- Held request: m0 keeps req high through its ack cycle. Expect exactly one access per ack and no duplicate strobe in the ack cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Two-master round-robin arbiter and access sequencer for the system bus.
// Master 0 is the CPU data port, master 1 a secondary requester. One word
// access at a time is driven to the address decoder. The block waits for the
// slave's ready, then returns read data with a one-cycle acknowledge. A
// watchdog aborts accesses whose slave never answers and flags a bus error.
//
// Parameters
//   TIMEOUT    cycles an access may wait for bus_ready before abort
//              (0 disables the watchdog)
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous active-low reset
//   m0_req / m1_req      access request, held until the matching ack
//   m0_we / m1_we        1 = write, 0 = read
//   m0_addr / m1_addr    byte address
//   m0_wdata / m1_wdata  write data
//   m0_rdata / m1_rdata  read data, valid while the matching ack is high
//   m0_ack / m1_ack      one-cycle completion pulse
//   bus_addr             word-aligned address to the decoder
//   bus_re / bus_we      read / write strobes (mutually exclusive)
//   bus_wdata            write data to the slave
//   bus_rdata            slave read data
//   bus_ready            slave completion, sampled only while a strobe is high
//   err                  one-cycle pulse on watchdog abort (same cycle as ack)
//   err_addr             address of the most recent aborted access (sticky)
//   owner                index of the current or last granted master
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] bus_addr,
  output logic        bus_re,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        err,
  output logic [31:0] err_addr,
  output logic        owner
);

  localparam int CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] LAST_COUNT = CW'(LAST_I);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Access fields captured at grant time; they stay frozen for the whole
  // access regardless of what the master does with its inputs.
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic          owner_q;
  logic [CW-1:0] count_q;
  logic [31:0]   rdata_q;
  logic [31:0]   err_addr_q;

  // Registered pulse/strobe outputs, so they never glitch.
  logic re_q;
  logic we_q;
  logic ack0_q;
  logic ack1_q;
  logic err_q;

  // Combinational decisions for the current cycle.
  logic        grant;
  logic        grant_sel;
  logic        done;
  logic        abort;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        re_next;
  logic        we_next;
  logic        ack0_next;
  logic        ack1_next;
  logic        err_next;

  // Fields of whichever master is being granted this cycle.
  assign sel_we    = grant_sel ? m1_we    : m0_we;
  assign sel_addr  = grant_sel ? m1_addr  : m0_addr;
  assign sel_wdata = grant_sel ? m1_wdata : m0_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output decode. On a tie the master that is not the
  // last owner wins, which makes service alternate under contention.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_sel  = owner_q;
    done       = 1'b0;
    abort      = 1'b0;
    re_next    = 1'b0;
    we_next    = 1'b0;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant = 1'b1;
          if (m0_req && m1_req) begin
            grant_sel = ~owner_q;
          end else begin
            grant_sel = m1_req;
          end
          re_next    = ~sel_we;
          we_next    = sel_we;
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        // Ready takes priority over a watchdog expiry on the same edge.
        if (bus_ready) begin
          done = 1'b1;
        end else if (WDOG_EN && (count_q == LAST_COUNT)) begin
          done  = 1'b1;
          abort = 1'b1;
        end

        if (done) begin
          ack0_next  = ~owner_q;
          ack1_next  = owner_q;
          err_next   = abort;
          state_next = RESP;
        end else begin
          re_next = re_q;
          we_next = we_q;
        end
      end

      // One dead cycle carrying the ack, so a request still held during
      // the ack is not mistaken for a new one.
      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latched access fields, watchdog counter, response data,
  // sticky error address and the registered strobes/pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      owner_q    <= 1'b1;
      count_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      re_q   <= re_next;
      we_q   <= we_next;
      ack0_q <= ack0_next;
      ack1_q <= ack1_next;
      err_q  <= err_next;

      if (grant) begin
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        owner_q   <= grant_sel;
        count_q   <= '0;
      end else if (state == ACCESS) begin
        count_q <= count_q + CW'(1);
      end

      // Writes and aborted accesses return zero data.
      if (done) begin
        rdata_q <= (abort || lat_we) ? 32'd0 : bus_rdata;
      end

      if (abort) begin
        err_addr_q <= lat_addr;
      end
    end
  end

  assign bus_addr  = {lat_addr[31:2], 2'b00};
  assign bus_wdata = lat_wdata;
  assign bus_re    = re_q;
  assign bus_we    = we_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = ack0_q ? rdata_q : 32'd0;
  assign m1_rdata  = ack1_q ? rdata_q : 32'd0;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed and randomized checks of bus_arbiter with a 4-cycle watchdog.
// The bench plays both masters and the slave. The expected grant order, strobe
// duration, returned data and error reporting come from a small
// transaction-level model of the arbitration and watchdog rules.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0;
  logic        m1_req = 1'b0;
  logic        m0_we = 1'b0;
  logic        m1_we = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [31:0] m1_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [31:0] m1_wdata = '0;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic        m0_ack;
  logic        m1_ack;
  logic [31:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        err;
  logic [31:0] err_addr;
  logic        owner;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Transaction-level model state.
  logic        model_owner = 1'b1;
  logic [31:0] model_err_addr = '0;
  int          last_ack_cycle = 0;
  int          first_strobe_cycle = 0;

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_we     (m0_we),
    .m1_we     (m1_we),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .m0_ack    (m0_ack),
    .m1_ack    (m1_ack),
    .bus_addr  (bus_addr),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .err       (err),
    .err_addr  (err_addr),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (m == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
  endtask

  task automatic dropReq(input int m);
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: a lone requester wins; on a tie the non-owner wins.
  function automatic int expectedGrant();
    if (m0_req && m1_req) return (model_owner == 1'b1) ? 0 : 1;
    return m1_req ? 1 : 0;
  endfunction

  // Plays the slave for one access: raises ready once the strobe has been
  // high for waitc+1 cycles, then checks the whole transaction against the
  // model. Returns the master index that was served.
  task automatic serveOne(input int waitc, input logic [31:0] sdata, output int acked);
    int          em;
    int          strobes;
    int          exp_strobes;
    int          ack_m;
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        got_ack;
    logic        two_acks;
    logic        ack_err;
    logic        strobe_in_ack;
    logic        stray_err;
    logic [31:0] ack_rdata;
    logic [31:0] other_rdata;

    em          = expectedGrant();
    exp_we      = (em == 1) ? m1_we    : m0_we;
    exp_addr    = (em == 1) ? m1_addr  : m0_addr;
    exp_wdata   = (em == 1) ? m1_wdata : m0_wdata;
    exp_err     = (TIMEOUT != 0) && (waitc >= TIMEOUT);
    exp_strobes = exp_err ? TIMEOUT : waitc + 1;
    exp_rdata   = (exp_we || exp_err) ? 32'd0 : sdata;

    strobes = 0; ack_m = em; got_ack = 1'b0; two_acks = 1'b0; ack_err = 1'b0;
    strobe_in_ack = 1'b0; stray_err = 1'b0; ack_rdata = '0; other_rdata = '0;
    bus_ready = 1'b0;
    bus_rdata = $urandom;

    for (int c = 0; c < 40 + TIMEOUT && !got_ack; c++) begin
      tick();
      if (m0_ack || m1_ack) begin
        got_ack       = 1'b1;
        ack_m         = m1_ack ? 1 : 0;
        two_acks      = m0_ack && m1_ack;
        ack_rdata     = m1_ack ? m1_rdata : m0_rdata;
        other_rdata   = m1_ack ? m0_rdata : m1_rdata;
        ack_err       = err;
        strobe_in_ack = bus_re || bus_we;
        last_ack_cycle = cycle;
      end else begin
        if (err) stray_err = 1'b1;
        if (bus_re || bus_we) begin
          strobes++;
          if (strobes == 1) first_strobe_cycle = cycle;
          checkOutput("bus_addr", bus_addr, {exp_addr[31:2], 2'b00});
          checkOutput("bus_wdata", bus_wdata, exp_wdata);
          checkOutput("strobe_re_we", {30'd0, bus_re, bus_we}, {30'd0, ~exp_we, exp_we});
          if (strobes > waitc) begin
            bus_ready = 1'b1;
            bus_rdata = sdata;
          end
        end
      end
    end
    bus_ready = 1'b0;

    checkOutput("ack_seen", {31'd0, got_ack}, 32'd1);
    if (got_ack) begin
      checkOutput("ack_master", ack_m, em);
      checkOutput("ack_both", {31'd0, two_acks}, 32'd0);
      checkOutput("ack_rdata", ack_rdata, exp_rdata);
      checkOutput("other_rdata", other_rdata, 32'd0);
      checkOutput("err_with_ack", {31'd0, ack_err}, {31'd0, exp_err});
      checkOutput("strobe_in_ack", {31'd0, strobe_in_ack}, 32'd0);
      checkOutput("strobe_cycles", strobes, exp_strobes);
      checkOutput("owner", {31'd0, owner}, em);
    end
    checkOutput("err_stray", {31'd0, stray_err}, 32'd0);

    model_owner = (em == 1);
    if (exp_err) model_err_addr = exp_addr;
    checkOutput("err_addr", err_addr, model_err_addr);
    acked = got_ack ? ack_m : em;
  endtask

  initial begin
    int m;
    int prev_ack;
    int start;
    int left0;
    int left1;
    int pat;

    $display("[TB] bus_arbiter bench start, TIMEOUT=%0d", TIMEOUT);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_strobes", {30'd0, bus_re, bus_we}, 32'd0);
    checkOutput("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_err_addr", err_addr, 32'd0);
    checkOutput("rst_owner", {31'd0, owner}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Contention with a zero-wait slave: 4 writes per master, alternating.
    left0 = 4; left1 = 4;
    applyStimulus(0, 1'b1, $urandom, $urandom);
    applyStimulus(1, 1'b1, $urandom, $urandom);
    prev_ack = 0;
    for (int i = 0; i < 8; i++) begin
      serveOne(0, $urandom, m);
      checkOutput("contention_order", m, i % 2);
      if (i > 0) checkOutput("ack_interval", last_ack_cycle - prev_ack, 3);
      prev_ack = last_ack_cycle;
      if (m == 0) begin
        left0--;
        if (left0 > 0) applyStimulus(0, 1'b1, $urandom, $urandom);
        else dropReq(0);
      end else begin
        left1--;
        if (left1 > 0) applyStimulus(1, 1'b1, $urandom, $urandom);
        else dropReq(1);
      end
    end
    tick();

    // Single read from m0 with two wait states.
    applyStimulus(0, 1'b0, 32'h1000_0007, $urandom);
    start = cycle;
    serveOne(2, 32'hDEAD_BEEF, m);
    checkOutput("single_first_strobe", first_strobe_cycle - start, 1);
    checkOutput("single_latency", last_ack_cycle - start, 4);
    dropReq(0);
    tick();

    // Watchdog: m1 read with a slave that never answers.
    applyStimulus(1, 1'b0, 32'hF090_0000, $urandom);
    serveOne(1000, $urandom, m);
    checkOutput("wdog_err_addr", err_addr, 32'hF090_0000);
    dropReq(1);
    tick();

    // The access after an abort proceeds normally.
    applyStimulus(0, 1'b0, $urandom, $urandom);
    serveOne(1, $urandom, m);
    dropReq(0);
    tick();

    // Ready arrives on the same edge the watchdog would fire.
    applyStimulus(1, 1'(($urandom % 2)), $urandom, $urandom);
    serveOne(TIMEOUT - 1, $urandom, m);
    dropReq(1);
    tick();

    // Randomized request patterns, wait states and data.
    for (int it = 0; it < 12; it++) begin
      pat = $urandom_range(1, 3);
      if (pat[0]) applyStimulus(0, 1'(($urandom % 2)), $urandom, $urandom);
      if (pat[1]) applyStimulus(1, 1'(($urandom % 2)), $urandom, $urandom);
      while (m0_req || m1_req) begin
        serveOne($urandom_range(0, 5), $urandom, m);
        dropReq(m);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Held request: m0 keeps req high through its ack.
    applyStimulus(0, 1'b0, $urandom, $urandom);
    serveOne(1, $urandom, m);
    prev_ack = last_ack_cycle;
    serveOne(0, $urandom, m);
    checkOutput("held_regrant_gap", first_strobe_cycle - prev_ack, 2);
    checkOutput("held_master", m, 0);
    dropReq(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("held_quiet", {28'd0, bus_re, bus_we, m0_ack, m1_ack}, 32'd0);
    end

    // Reset in the middle of a write access.
    applyStimulus(1, 1'b1, $urandom, $urandom);
    bus_ready = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_we", {31'd0, bus_we}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_strobes", {30'd0, bus_re, bus_we}, 32'd0);
    checkOutput("mid_reset_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
    checkOutput("mid_reset_bus_addr", bus_addr, 32'd0);
    checkOutput("mid_reset_bus_wdata", bus_wdata, 32'd0);
    checkOutput("mid_reset_rdata", m0_rdata | m1_rdata, 32'd0);
    checkOutput("mid_reset_err", {31'd0, err}, 32'd0);
    checkOutput("mid_reset_err_addr", err_addr, 32'd0);
    checkOutput("mid_reset_owner", {31'd0, owner}, 32'd1);
    dropReq(1);
    model_owner = 1'b1;
    model_err_addr = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_reset_quiet", {28'd0, bus_re, bus_we, m0_ack, m1_ack}, 32'd0);
    end

    // Tie right after reset goes to m0 first, then m1.
    applyStimulus(0, 1'(($urandom % 2)), $urandom, $urandom);
    applyStimulus(1, 1'(($urandom % 2)), $urandom, $urandom);
    serveOne($urandom_range(0, 2), $urandom, m);
    checkOutput("post_reset_first", m, 0);
    dropReq(m);
    serveOne($urandom_range(0, 2), $urandom, m);
    checkOutput("post_reset_second", m, 1);
    dropReq(m);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
